// File: rtl/imgproc_msg_arbiter.sv
// Round-robin arbiter sharing the message FIFO write port at whole-message granularity.
// Optional macro IMGPROC_ARB_PRIORITY0_EN gives requester 0 strict priority in IDLE.
module imgproc_msg_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FIFO_DEPTH    = 256,
  parameter int USEDW_W       = 8,
  parameter int MAX_MSG_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            fifo_data,
  output logic                   fifo_wrreq,
  input  logic [USEDW_W-1:0]     fifo_usedw,
  input  logic                   flush,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   err_overlong,
  output logic [15:0]            msg_count
);
  localparam int CNT_W       = $clog2(MAX_MSG_WORDS + 1);
  localparam int SPACE_LIMIT = FIFO_DEPTH - 1 - MAX_MSG_WORDS;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           r_state;
  logic [2:0]       r_grant_id;
  logic [2:0]       r_last_grant;
  logic             r_busy;
  logic             r_err;
  logic [15:0]      r_msg_count;
  logic [CNT_W-1:0] r_wcnt;

  logic [7:0]       w_rr_valid;
  logic             w_rr_found;
  logic [2:0]       w_rr_winner;
  logic [2:0]       w_cand;
  logic             w_found;
  logic [2:0]       w_winner;
  logic             w_space;
  logic             w_own_valid;
  logic             w_own_last;
  logic             w_accept;
  logic             w_upd_last;

  // A whole MAX_MSG_WORDS message must fit before any grant is issued.
  assign w_space = (int'(fifo_usedw) <= SPACE_LIMIT);

  always_comb begin
    w_rr_valid  = 8'(req_valid);
    w_rr_found  = 1'b0;
    w_rr_winner = 3'd0;
    w_cand      = 3'd0;
`ifdef IMGPROC_ARB_PRIORITY0_EN
    w_rr_valid[0] = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = 3'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_rr_found && w_rr_valid[w_cand]) begin
        w_rr_found  = 1'b1;
        w_rr_winner = w_cand;
      end
    end
  end

`ifdef IMGPROC_ARB_PRIORITY0_EN
  assign w_found    = req_valid[0] | w_rr_found;
  assign w_winner   = req_valid[0] ? 3'd0 : w_rr_winner;
  assign w_upd_last = (r_grant_id != 3'd0);
`else
  assign w_found    = w_rr_found;
  assign w_winner   = w_rr_winner;
  assign w_upd_last = 1'b1;
`endif

  always_comb begin
    fifo_data   = '0;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        fifo_data    = req_data[32*i +: 32];
        w_own_valid  = req_valid[i];
        w_own_last   = req_last[i];
        req_ready[i] = (r_state == BURST) && !flush;
      end
    end
  end

  assign w_accept   = w_own_valid && (r_state == BURST) && !flush;
  assign fifo_wrreq = w_accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_grant_id   <= 3'd0;
      r_last_grant <= 3'(NUM_REQ - 1);
      r_err        <= 1'b0;
      r_msg_count  <= 16'd0;
      r_wcnt       <= '0;
    end else if (flush) begin
      // last_grant survives a flush so fairness carries over.
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_wcnt      <= '0;
      r_msg_count <= 16'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found && w_space) begin
            r_grant_id <= w_winner;
            r_busy     <= 1'b1;
            r_wcnt     <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_own_last) begin
              if (r_msg_count != 16'hFFFF) r_msg_count <= r_msg_count + 16'd1;
              if (w_upd_last) r_last_grant <= r_grant_id;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else if (r_wcnt == CNT_W'(MAX_MSG_WORDS - 1)) begin
              r_err   <= 1'b1;
              if (w_upd_last) r_last_grant <= r_grant_id;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id     = r_grant_id;
  assign busy         = r_busy;
  assign err_overlong = r_err;
  assign msg_count    = r_msg_count;
endmodule

// File: tb/tb_imgproc_msg_arbiter.sv
// Directed bench for imgproc_msg_arbiter (4 requesters, 256-word FIFO, 4-word messages).
module tb_imgproc_msg_arbiter;
  logic         clk;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic [31:0]  fifo_data;
  logic         fifo_wrreq;
  logic [7:0]   fifo_usedw;
  logic         flush;
  logic [2:0]   grant_id;
  logic         busy;
  logic         err_overlong;
  logic [15:0]  msg_count;

  int checks   = 0;
  int failures = 0;

  imgproc_msg_arbiter #(
    .NUM_REQ(4), .FIFO_DEPTH(256), .USEDW_W(8), .MAX_MSG_WORDS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_data(fifo_data),
    .fifo_wrreq(fifo_wrreq), .fifo_usedw(fifo_usedw), .flush(flush),
    .grant_id(grant_id), .busy(busy), .err_overlong(err_overlong),
    .msg_count(msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int w [4];

  task automatic drive_all();
    for (int i = 0; i < 4; i++) begin
      req_data[32*i +: 32] = {16'hA000 + 16'(i), 16'(w[i])};
      req_last[i]          = (w[i] == 1);
    end
  endtask

  initial begin
    int order [5];
    int o;
    int exp2;
    order = '{0, 1, 2, 3, 0};

    reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    fifo_usedw = '0; flush = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_msgcnt", 32'(msg_count), 0);
    chk("rst_err", 32'(err_overlong), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wrreq", 32'(fifo_wrreq), 0);
    reset_n = 1'b1;

    // Single two-word message from requester 1
    req_valid = 4'b0010; req_data[63:32] = 32'h0052_1234; req_last = 4'b0000;
    #1;
    chk("t1_idle_ready", 32'(req_ready), 0);
    chk("t1_idle_wr", 32'(fifo_wrreq), 0);
    step();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_grant", 32'(grant_id), 1);
    chk("t1_wr0", 32'(fifo_wrreq), 1);
    chk("t1_data0", fifo_data, 32'h0052_1234);
    chk("t1_ready", 32'(req_ready), 32'h2);
    step();
    req_data[63:32] = 32'h0352_5678; req_last = 4'b0010;
    #1;
    chk("t1_wr1", 32'(fifo_wrreq), 1);
    chk("t1_data1", fifo_data, 32'h0352_5678);
    step();
    req_valid = '0; req_last = '0;
    #1;
    chk("t1_done_busy", 32'(busy), 0);
    chk("t1_msgcnt", 32'(msg_count), 1);
    chk("t1_done_wr", 32'(fifo_wrreq), 0);

    // Reset restores last_grant=3, then all four contend with 2-word messages
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) w[i] = 0;
    req_valid = 4'hF;
    for (int m = 0; m < 5; m++) begin
      o = order[m];
      drive_all(); #1;
      chk("rr_idle_busy", 32'(busy), 0);
      chk("rr_idle_wr", 32'(fifo_wrreq), 0);
      step();
      chk("rr_grant", 32'(grant_id), 32'(o));
      chk("rr_wr0", 32'(fifo_wrreq), 1);
      chk("rr_data0", fifo_data, {16'hA000 + 16'(o), 16'h0000});
      chk("rr_ready", 32'(req_ready), 32'(1 << o));
      step();
      w[o] = 1; drive_all(); #1;
      chk("rr_wr1", 32'(fifo_wrreq), 1);
      chk("rr_data1", fifo_data, {16'hA000 + 16'(o), 16'h0001});
      step();
      w[o] = 0;
    end
    req_valid = '0; req_last = '0;
    #1;
    chk("rr_msgcnt", 32'(msg_count), 5);

    // Space gating: 252 used blocks, 251 admits
    fifo_usedw = 8'd252; req_valid = 4'b0100; req_last = 4'b0100;
    req_data[95:64] = 32'h0000_00C2;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("sp_nogrant_busy", 32'(busy), 0);
      chk("sp_nogrant_ready", 32'(req_ready), 0);
    end
    fifo_usedw = 8'd251;
    step();
    chk("sp_grant_busy", 32'(busy), 1);
    chk("sp_grant_id", 32'(grant_id), 2);
    chk("sp_data", fifo_data, 32'h0000_00C2);
    chk("sp_wr", 32'(fifo_wrreq), 1);
    step();
    req_valid = '0; req_last = '0; fifo_usedw = '0;
    #1;
    chk("sp_msgcnt", 32'(msg_count), 6);

    // Overlong message from requester 0
    req_valid = 4'b0001; req_last = '0; req_data[31:0] = 32'h0000_0100;
    step();
    chk("ol_grant", 32'(grant_id), 0);
    for (int n = 0; n < 4; n++) begin
      req_data[31:0] = 32'h0000_0100 + 32'(n); #1;
      chk("ol_wr", 32'(fifo_wrreq), 1);
      chk("ol_data", fifo_data, 32'h0000_0100 + 32'(n));
      chk("ol_err_pre", 32'(err_overlong), 0);
      step();
    end
    req_data[31:0] = 32'h0000_0104; req_last = 4'b0001; #1;
    chk("ol_err", 32'(err_overlong), 1);
    chk("ol_busy", 32'(busy), 0);
    chk("ol_msgcnt", 32'(msg_count), 6);
    chk("ol_idle_wr", 32'(fifo_wrreq), 0);
    step();
    chk("ol_regrant", 32'(busy), 1);
    chk("ol_data5", fifo_data, 32'h0000_0104);
    step();
    req_valid = '0; req_last = '0; #1;
    chk("ol_msgcnt2", 32'(msg_count), 7);
    chk("ol_err_sticky", 32'(err_overlong), 1);

    // Flush mid-burst; last_grant (0) is kept so requester 1 wins over 2
    req_valid = 4'b0010; req_data[63:32] = 32'h0000_0A10; req_last = '0;
    step();
    chk("fl_grant", 32'(grant_id), 1);
    step();
    req_data[63:32] = 32'h0000_0A11; req_last = 4'b0010; flush = 1'b1; #1;
    chk("fl_nowr", 32'(fifo_wrreq), 0);
    chk("fl_noready", 32'(req_ready), 0);
    step();
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 0);
    chk("fl_msgcnt", 32'(msg_count), 0);
    chk("fl_err", 32'(err_overlong), 0);
    req_valid = 4'b0110; req_data[63:32] = 32'h0000_0A10; req_last = '0;
    req_data[95:64] = 32'h0000_0C00;
    step();
    chk("fl_next_grant", 32'(grant_id), 1);
    step();
    req_data[63:32] = 32'h0000_0A11; req_last = 4'b0010; #1;
    chk("fl_data1", fifo_data, 32'h0000_0A11);
    step();
    req_valid = '0; req_last = '0; #1;
    chk("fl_msgcnt2", 32'(msg_count), 1);

    // Requesters 0 and 2 contending with single-word messages
    req_valid = 4'b0101; req_last = 4'b0101;
    req_data[31:0] = 32'h0000_0F00; req_data[95:64] = 32'h0000_0F02;
    for (int m = 0; m < 4; m++) begin
      step();
`ifdef IMGPROC_ARB_PRIORITY0_EN
      exp2 = 0;
`else
      exp2 = (m % 2 == 0) ? 2 : 0;
`endif
      chk("pr_grant", 32'(grant_id), 32'(exp2));
      chk("pr_data", fifo_data, 32'h0000_0F00 + 32'(exp2));
      step();
    end
    req_valid = 4'b0100;
    step();
    chk("pr_req2_grant", 32'(grant_id), 2);
    step();
    req_valid = '0; req_last = '0; #1;
    chk("pr_msgcnt", 32'(msg_count), 6);
    chk("pr_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
